// File: rtl/addsub_result_stage.sv
// Registered result stage for the 32-bit adder-subtractor: NZCV flags, 2-entry skid buffer, overflow counter.
// Optional signed saturation of overflowed results is enabled by defining ADDSUB_SAT_EN.
module addsub_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t             occ, occ_nxt;
  logic             push, pop;
  logic             wr_ptr, rd_ptr;
  logic [WIDTH-1:0] slot_res [2];
  logic [3:0]       slot_flg [2];

  logic [WIDTH-1:0] result;
  logic             flag_n, flag_z, flag_c, flag_v;

  // Handshake outputs depend only on registered occupancy.
  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_nxt = occ;
    case (occ)
      OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_nxt = OCC_FULL;
        else if (!push && pop) occ_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
      default:   occ_nxt = OCC_EMPTY;
    endcase
  end

  always_comb begin
    flag_c = sub ? (a >= b) : (sum < a);
    flag_v = sub ? ((a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                 : ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]));
`ifdef ADDSUB_SAT_EN
    if (flag_v)
      result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      result = sum;
`else
    result = sum;
`endif
    flag_n = result[WIDTH-1];
    flag_z = (result == '0);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      occ     <= OCC_EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ovf_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        slot_res[i] <= '0;
        slot_flg[i] <= '0;
      end
    end else begin
      occ <= occ_nxt;
      if (push) begin
        slot_res[wr_ptr] <= result;
        slot_flg[wr_ptr] <= {flag_n, flag_z, flag_c, flag_v};
        wr_ptr           <= ~wr_ptr;
        if (flag_v && (ovf_cnt != '1))
          ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

  assign out_result = slot_res[rd_ptr];
  assign out_flags  = slot_flg[rd_ptr];

endmodule

// File: tb/tb_addsub_result_stage.sv
// Scoreboard bench for addsub_result_stage: independent NZCV/saturation model, FIFO order, backpressure, reset.
module tb_addsub_result_stage;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b, sum;
  logic        sub;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;
  int rel_cnt = 0;
  int exp_ovf = 0;
  logic [35:0] sb_q [$];

  addsub_result_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .areset_n(areset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sum(sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {N,Z,C,V,result} derived with wide arithmetic.
  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    logic [32:0] wide;
    longint      sr;
    logic [31:0] res;
    logic        c, v;
    if (ms) begin
      wide = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
      sr   = longint'($signed(ma)) - longint'($signed(mb));
    end else begin
      wide = {1'b0, ma} + {1'b0, mb};
      sr   = longint'($signed(ma)) + longint'($signed(mb));
    end
    c   = wide[32];
    v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    res = wide[31:0];
`ifdef ADDSUB_SAT_EN
    if (v) res = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {res[31], (res == 32'd0), c, v, res};
  endfunction

  always @(negedge clk) begin
    logic [35:0] e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", out_result, e[31:0]);
        check("sb_flags", {28'd0, out_flags}, {28'd0, e[35:32]});
      end
      rel_cnt++;
    end
    if (in_valid && in_ready) begin
      e = model(a, b, sub);
      sb_q.push_back(e);
      if (e[32] && exp_ovf < 255) exp_ovf++;
    end
  end

  task automatic set_in(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    in_valid = 1'b1;
    a = ta; b = tb; sub = ts;
    sum = ts ? ta - tb : ta + tb;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    logic acc;
    acc = 1'b0;
    set_in(ta, tb, ts);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [35:0] e0;
    int          rel_before;
    areset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sum = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {28'd0, out_flags}, 32'd0);
    check("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
    areset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors, checked in place as well as by the scoreboard.
    out_ready = 1'b1;
    drive(32'd5, 32'd3, 1'b1);
    check("v1_valid", {31'd0, out_valid}, 32'd1);
    check("v1_result", out_result, 32'd2);
    check("v1_flags", {28'd0, out_flags}, 32'b0010);
    check("v1_ovf", {24'd0, ovf_cnt}, 32'd0);
    idle(1);
    drive(32'h7FFF_FFFF, 32'd1, 1'b0);
`ifdef ADDSUB_SAT_EN
    check("v2_result", out_result, 32'h7FFF_FFFF);
    check("v2_flags", {28'd0, out_flags}, 32'b0001);
`else
    check("v2_result", out_result, 32'h8000_0000);
    check("v2_flags", {28'd0, out_flags}, 32'b1001);
`endif
    check("v2_ovf", {24'd0, ovf_cnt}, 32'd1);
    idle(1);
    drive(32'd3, 32'd3, 1'b1);
    check("v3_flags", {28'd0, out_flags}, 32'b0110);
    idle(1);
    drive(32'd0, 32'd1, 1'b1);
    check("v4_result", out_result, 32'hFFFF_FFFF);
    check("v4_flags", {28'd0, out_flags}, 32'b1000);
    idle(2);

    // Backpressure: two accepted, third stalls until a slot frees.
    out_ready = 1'b0;
    set_in(32'h1000_0000, 32'h0000_0011, 1'b0);
    e0 = model(32'h1000_0000, 32'h0000_0011, 1'b0);
    @(posedge clk); #1;
    set_in(32'h0000_0001, 32'h0000_0002, 1'b1);
    @(posedge clk); #1;
    set_in(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("stall_result", out_result, e0[31:0]);
    check("stall_flags", {28'd0, out_flags}, {28'd0, e0[35:32]});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous accept and release at occupancy 1.
    out_ready = 1'b0;
    drive(32'd100, 32'd1, 1'b0);
    out_ready = 1'b1;
    rel_before = rel_cnt;
    for (int i = 0; i < 10; i++) begin
      set_in(32'd200 + i, 32'd7 * i, i[0]);
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      check("stream_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_empty", {31'd0, out_valid}, 32'd0);
    check("stream_count", rel_cnt - rel_before, 32'd11);

    // Overflow counter saturation (positive add and negative sub overflows).
    for (int i = 0; i < 300; i++) begin
      if (i[0]) drive(32'h8000_0000, 32'd1, 1'b1);
      else      drive(32'h7FFF_FFFF, 32'd1 + i, 1'b0);
      if (i == 100) check("ovf_mid", {24'd0, ovf_cnt}, exp_ovf);
    end
    idle(2);
    check("ovf_model", {24'd0, ovf_cnt}, exp_ovf);
    check("ovf_sat", {24'd0, ovf_cnt}, 32'd255);

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    drive(32'd9, 32'd4, 1'b1);
    drive(32'd9, 32'd4, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    areset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ovf", {24'd0, ovf_cnt}, 32'd0);
    check("arst_result", out_result, 32'd0);
    sb_q.delete();
    exp_ovf = 0;
    @(posedge clk); #1;
    areset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(2);
    check("post_rst_ovf", {24'd0, ovf_cnt}, 32'd1);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
